// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - APB register file responder with wait states and error decode
module apb_slave_regfile #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REGS    = 8,
  parameter int                    WAIT_STATES = 0,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA0B0_0001
) (
  input  logic                           HCLK,
  input  logic                           HRESETn,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic [ADDR_WIDTH-1:0]          PADDR,
  input  logic                           PWRITE,
  input  logic [DATA_WIDTH-1:0]          PWDATA,
  output logic [DATA_WIDTH-1:0]          PRDATA,
  output logic                           PREADY,
  output logic                           PSLVERR,
  output logic [NUM_REGS*DATA_WIDTH-1:0] REGS_OUT
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    write_q, write_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
  logic                    pready_q, pready_d;
  logic                    pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0]   regs_q [1:NUM_REGS-1];
  logic [DATA_WIDTH-1:0]   regs_d [1:NUM_REGS-1];

  logic [ADDR_WIDTH-1:0]   dec_addr;
  logic                    dec_write;
  logic [IDX_W-1:0]        dec_idx;
  logic                    dec_err;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic                    commit;

  // Decode the transfer: live setup values while idle (they are being latched this edge), latched copy once in ACCESS
  always_comb begin
    dec_addr  = (state_q == ST_IDLE) ? PADDR : addr_q;
    dec_write = (state_q == ST_IDLE) ? PWRITE : write_q;
    dec_idx   = dec_addr[ADDR_WIDTH-1:2];
    dec_err   = !((dec_addr[1:0] == 2'b00) && (dec_idx < IDX_W'(NUM_REGS)))
                || (dec_write && (dec_idx == '0));
    rd_word   = ID_VALUE;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (dec_idx == IDX_W'(i)) rd_word = regs_q[i];
    end
  end

  // Transfer FSM: setup latch, wait-state countdown, response load, completion and abort
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    prdata_d  = prdata_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    commit    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d  = ST_ACCESS;
          addr_d   = PADDR;
          write_d  = PWRITE;
          wdata_d  = PWDATA;
          cnt_d    = CNT_W'(WAIT_STATES);
          pready_d = (WAIT_STATES == 0);
          if (WAIT_STATES == 0) begin
            pslverr_d = dec_err;
            if (!dec_write) prdata_d = dec_err ? '0 : rd_word;
          end
        end
      end
      ST_ACCESS: begin
        if (!PSEL) begin
          state_d   = ST_IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
        end else if (PENABLE && !pready_q) begin
          cnt_d    = cnt_q - 1'b1;
          pready_d = (cnt_q == CNT_W'(1));
          if (cnt_q == CNT_W'(1)) begin
            pslverr_d = dec_err;
            if (!dec_write) prdata_d = dec_err ? '0 : rd_word;
          end
        end else if (PENABLE && pready_q) begin
          commit    = write_q && !dec_err;
          state_d   = ST_IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Register file next state: only a clean completing write touches a register
  always_comb begin
    regs_d = regs_q;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (commit && (dec_idx == IDX_W'(i))) regs_d[i] = wdata_q;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      regs_q    <= regs_d;
    end
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;

  // Flatten register contents, with the constant ID in slot 0
  always_comb begin
    REGS_OUT = '0;
    REGS_OUT[0 +: DATA_WIDTH] = ID_VALUE;
    for (int i = 1; i < NUM_REGS; i++) REGS_OUT[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
  end

endmodule
